imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Boot-time program loader sitting directly upstream of the single-cycle CPU's instruction memory. It accepts 32-bit instruction words on a valid/ready stream, writes them to consecutive word addresses from 0, and optionally pads the remaining words with NOP (0x00000000). It holds the CPU stopped (cpu_run=0) until the image is complete. It also supports a reload request that re-stops the CPU and reloads.

Parameters:
ADDR_WIDTH, 8, instruction memory word-address width; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 32, instruction word width
FILL_NOP, 1, 1 = pad addresses after the last loaded word with 0x00000000; 0 = no padding

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high reset
s_valid  in  1  stream word valid
s_ready  out  1  loader can accept a word
s_data  in  DATA_WIDTH  instruction word
s_last  in  1  marks final word of the program image
reload  in  1  single-cycle request to stop the CPU and reload; honoured only in RUN or ERR
imem_we  out  1  instruction memory write strobe
imem_addr  out  ADDR_WIDTH  instruction memory word address
imem_wdata  out  DATA_WIDTH  instruction memory write data
cpu_run  out  1  CPU clock-enable / release; CPU must not fetch while 0
load_done  out  1  image loaded and CPU released
error  out  1  image exceeded DEPTH words
word_count  out  ADDR_WIDTH+1  number of stream words accepted in the current load

Behaviour:
- Reset is synchronous and active-high; clk is the only clock. While reset=1: state=LOAD, ptr=0, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_run=0, load_done=0, error=0, word_count=0.
- States: LOAD, FILL, START, RUN, ERR.
- s_ready = (state==LOAD) && !reset. This is combinational from the state register. Beat accept = s_valid && s_ready at a rising edge.
- LOAD, on accept:
  - At that edge: imem_we<=1, imem_addr<=ptr, imem_wdata<=s_data (1-cycle write latency); word_count++.
  - If s_last=1: go to FILL when FILL_NOP=1 and ptr<DEPTH-1; otherwise go to START.
  - If s_last=0 and ptr==DEPTH-1: go to ERR. The word at DEPTH-1 is still written.
  - If s_last=0 and ptr<DEPTH-1: ptr++ and stay in LOAD.
- LOAD, no accept: imem_we<=0 and all other registers hold. Bubbles on s_valid are legal at any point.
- FILL: each cycle write imem_addr<=ptr+1 with wdata 0 and imem_we=1, then ptr++. When the written address is DEPTH-1, go to START. Stream is stalled (s_ready=0).
- START: imem_we<=0; next edge cpu_run<=1, load_done<=1, state<=RUN. cpu_run therefore rises exactly one cycle after the final imem_we cycle, so the CPU never fetches a word being written.
- RUN: all memory outputs idle (imem_we=0); cpu_run=1 and load_done=1 held.
- ERR: error=1, cpu_run=0, load_done=0, s_ready=0, imem_we=0. Extra stream words are not accepted. Exit only via reset or reload.
- reload=1 in RUN or ERR: at the next edge state<=LOAD, ptr<=0, word_count<=0, cpu_run<=0, load_done<=0, error<=0.
- reload in LOAD/FILL/START is ignored. reload and reset together: reset wins (identical result).
- Reset asserted mid-LOAD or mid-FILL aborts the load; memory contents already written are not cleared.
- Single-word image (s_last on first beat) is legal: writes address 0, then FILL 1..DEPTH-1 (if enabled).
- word_count saturates naturally at DEPTH; it never wraps because overflow enters ERR.
- imem_addr and imem_wdata hold their last values when imem_we=0.

Test Plan:
- ADDR_WIDTH=3, FILL_NOP=1; stream 3 words 0x20100005, 0x20110003, 0x02119020 (last on 3rd) -> imem_we pulses at addresses 0,1,2 with those data, then 3..7 with 0x00000000; cpu_run=1 one cycle after the address-7 write; word_count=3; error=0.
- Same stream with s_valid toggled 1-0-1-0-1 -> identical memory writes and addresses; s_ready stays 1 throughout LOAD; no duplicate writes.
- ADDR_WIDTH=3; stream 9 words with no s_last -> words 0..7 written; s_ready=0 after the 8th accept; error=1; cpu_run=0; 9th word never accepted; word_count=8.
- ADDR_WIDTH=3, FILL_NOP=0; 8 words with s_last on the 8th -> no FILL writes; cpu_run=1 two cycles after the last accept; load_done=1.
- In RUN, pulse reload, then stream 1 word 0xDEADBEEF with s_last -> cpu_run=0 the cycle after reload; address 0=0xDEADBEEF; addresses 1..7 zero-filled; cpu_run returns to 1; word_count=1.
- Assert reset after 2 accepted words of a 5-word load, then restart the full load -> all outputs return to reset values within one edge; new load begins at address 0; final word_count=5.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: streams a program image into instruction memory, optionally
// pads the tail with NOPs, and holds the CPU stopped until the image is in.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter bit FILL_NOP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_run,
    output logic                  load_done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ONE_A     = 1;
    localparam logic [ADDR_WIDTH:0]   ONE_C     = 1;

    typedef enum logic [2:0] {
        LOAD,
        FILL,
        START,
        RUN,
        ERR
    } state_t;

    state_t state, state_d;

    logic [ADDR_WIDTH-1:0] ptr, ptr_d, ptr_inc;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  run_d, done_d, err_d;
    logic [ADDR_WIDTH:0]   cnt_d;
    logic                  accept;

    assign s_ready = (state == LOAD) && !reset;
    assign accept  = s_valid && s_ready;
    assign ptr_inc = ptr + ONE_A;

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            LOAD: begin
                if (accept) begin
                    if (s_last)
                        state_d = (FILL_NOP && ptr != LAST_ADDR) ? FILL : START;
                    else if (ptr == LAST_ADDR)
                        state_d = ERR;
                end
            end
            FILL:     if (ptr_inc == LAST_ADDR) state_d = START;
            START:    state_d = RUN;
            RUN, ERR: if (reload) state_d = LOAD;
            default:  state_d = LOAD;
        endcase
    end

    // Next values of the registered outputs; memory address/data hold when idle.
    always_comb begin
        ptr_d   = ptr;
        we_d    = 1'b0;
        addr_d  = imem_addr;
        wdata_d = imem_wdata;
        run_d   = cpu_run;
        done_d  = load_done;
        err_d   = error;
        cnt_d   = word_count;
        unique case (state)
            LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = ptr;
                    wdata_d = s_data;
                    cnt_d   = word_count + ONE_C;
                    if (!s_last && ptr != LAST_ADDR) ptr_d = ptr_inc;
                    if (!s_last && ptr == LAST_ADDR) err_d = 1'b1;
                end
            end
            FILL: begin
                we_d    = 1'b1;
                addr_d  = ptr_inc;
                wdata_d = '0;
                ptr_d   = ptr_inc;
            end
            START: begin
                run_d  = 1'b1;
                done_d = 1'b1;
            end
            RUN, ERR: begin
                if (reload) begin
                    ptr_d  = '0;
                    cnt_d  = '0;
                    run_d  = 1'b0;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_run    <= 1'b0;
            load_done  <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            ptr        <= ptr_d;
            imem_we    <= we_d;
            imem_addr  <= addr_d;
            imem_wdata <= wdata_d;
            cpu_run    <= run_d;
            load_done  <= done_d;
            error      <= err_d;
            word_count <= cnt_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: two instances (with and without NOP padding)
// checked against a write-log reference model.
module tb_imem_loader;

    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    typedef logic [AW+DW-1:0] ent_t;
    typedef ent_t ent_q[$];
    typedef logic [DW-1:0] word_q[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic s_valid1 = 1'b0;
    logic s_valid0 = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic s_last = 1'b0;
    logic reload = 1'b0;

    logic s_ready1, imem_we1, cpu_run1, load_done1, error1;
    logic [AW-1:0] imem_addr1;
    logic [DW-1:0] imem_wdata1;
    logic [AW:0] word_count1;

    logic s_ready0, imem_we0, cpu_run0, load_done0, error0;
    logic [AW-1:0] imem_addr0;
    logic [DW-1:0] imem_wdata0;
    logic [AW:0] word_count0;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FILL_NOP(1'b1)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid1), .s_ready(s_ready1),
        .s_data(s_data), .s_last(s_last), .reload(reload),
        .imem_we(imem_we1), .imem_addr(imem_addr1),
        .imem_wdata(imem_wdata1), .cpu_run(cpu_run1),
        .load_done(load_done1), .error(error1),
        .word_count(word_count1)
    );

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FILL_NOP(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .s_valid(s_valid0), .s_ready(s_ready0),
        .s_data(s_data), .s_last(s_last), .reload(reload),
        .imem_we(imem_we0), .imem_addr(imem_addr0),
        .imem_wdata(imem_wdata0), .cpu_run(cpu_run0),
        .load_done(load_done0), .error(error0),
        .word_count(word_count0)
    );

    // Write-log monitor: records every memory write and cpu_run rise timing.
    ent_q log1, log0;
    int cyc = 0;
    int we_last1 = -1, rise1 = -1, overlap1 = 0;
    int we_last0 = -1, rise0 = -1, overlap0 = 0;
    logic run_prev1 = 1'b0, run_prev0 = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (imem_we1 === 1'b1) begin
            log1.push_back({imem_addr1, imem_wdata1});
            we_last1 = cyc;
        end
        if (imem_we0 === 1'b1) begin
            log0.push_back({imem_addr0, imem_wdata0});
            we_last0 = cyc;
        end
        if (cpu_run1 === 1'b1 && run_prev1 !== 1'b1) rise1 = cyc;
        if (cpu_run0 === 1'b1 && run_prev0 !== 1'b1) rise0 = cyc;
        if (cpu_run1 === 1'b1 && imem_we1 === 1'b1) overlap1++;
        if (cpu_run0 === 1'b1 && imem_we0 === 1'b1) overlap0++;
        run_prev1 = cpu_run1;
        run_prev0 = cpu_run0;
    end

    task automatic clear_logs();
        log1.delete();
        log0.delete();
        we_last1 = -1; rise1 = -1; overlap1 = 0;
        we_last0 = -1; rise0 = -1; overlap0 = 0;
    endtask

    // Reference: words land at 0.., padded with zeros to DEPTH-1 when the image
    // ends early with padding on; an image past DEPTH is truncated at DEPTH.
    function automatic ent_q model(input word_q w, input bit with_last, input bit fill);
        ent_q q;
        int n;
        n = (w.size() > DEPTH) ? DEPTH : w.size();
        for (int i = 0; i < n; i++) q.push_back({AW'(i), w[i]});
        if (with_last && fill)
            for (int i = n; i < DEPTH; i++) q.push_back({AW'(i), 32'h0});
        return q;
    endfunction

    function automatic word_q rand_words(input int n);
        word_q w;
        for (int i = 0; i < n; i++) w.push_back($urandom);
        return w;
    endfunction

    // mode 0: back-to-back, 1: alternate valid/bubble, 2: random bubbles
    task automatic drive(input word_q w, input bit with_last, input bit inst0,
                         input int mode, output int acc_n, output int rdy_low);
        int idx, budget;
        bit bub, rdy;
        idx = 0; budget = 0; rdy_low = 0;
        while (idx < w.size() && budget < 40) begin
            @(negedge clk);
            budget++;
            if (mode == 1) bub = (budget % 2 == 0);
            else if (mode == 2) bub = ($urandom_range(0, 3) == 0);
            else bub = 1'b0;
            rdy = 1'b0;
            if (bub) begin
                s_valid1 = 1'b0;
                s_valid0 = 1'b0;
                s_last = 1'b0;
            end else begin
                s_data = w[idx];
                s_last = with_last && (idx == w.size() - 1);
                if (inst0) s_valid0 = 1'b1;
                else s_valid1 = 1'b1;
                rdy = inst0 ? s_ready0 : s_ready1;
                if (!rdy) rdy_low++;
            end
            @(posedge clk);
            if (!bub && rdy) idx++;
        end
        @(negedge clk);
        s_valid1 = 1'b0;
        s_valid0 = 1'b0;
        s_last = 1'b0;
        acc_n = idx;
    endtask

    task automatic settle(input bit inst0);
        int k;
        k = 0;
        while (k < 30 && !(inst0 ? (cpu_run0 || error0) : (cpu_run1 || error1))) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({s_ready1, imem_we1, imem_addr1, imem_wdata1, cpu_run1,
             load_done1, error1, word_count1} !== '0)
            $display("FAIL reset_outputs got rdy=%b we=%b addr=%0d wd=%h run=%b done=%b err=%b wc=%0d want all 0",
                     s_ready1, imem_we1, imem_addr1, imem_wdata1, cpu_run1,
                     load_done1, error1, word_count1);
        else passed++;
        total++;
        if ({s_ready0, imem_we0, cpu_run0, error0, word_count0} !== '0)
            $display("FAIL reset_outputs_nofill got rdy=%b we=%b run=%b err=%b wc=%0d want 0",
                     s_ready0, imem_we0, cpu_run0, error0, word_count0);
        else passed++;
        reset = 1'b0;
        clear_logs();
        @(negedge clk);
        total++;
        if (s_ready1 !== 1'b1) $display("FAIL reset_release_ready got %b want 1", s_ready1);
        else passed++;
    endtask

    task automatic test_basic();
        word_q w;
        ent_q exp;
        int acc, low;
        w = '{32'h20100005, 32'h20110003, 32'h02119020};
        exp = model(w, 1'b1, 1'b1);
        drive(w, 1'b1, 1'b0, 0, acc, low);
        settle(1'b0);
        total++;
        if (log1.size() !== exp.size())
            $display("FAIL basic_len got %0d want %0d", log1.size(), exp.size());
        else passed++;
        foreach (exp[i]) begin
            total++;
            if (i >= log1.size() || log1[i] !== exp[i])
                $display("FAIL basic_write[%0d] got %h want %h", i,
                         (i < log1.size()) ? log1[i] : '0, exp[i]);
            else passed++;
        end
        total++;
        if ({cpu_run1, load_done1, error1, word_count1} !== {1'b1, 1'b1, 1'b0, 4'd3})
            $display("FAIL basic_flags got run=%b done=%b err=%b wc=%0d want 1 1 0 3",
                     cpu_run1, load_done1, error1, word_count1);
        else passed++;
        total++;
        if (rise1 !== we_last1 + 1 || overlap1 !== 0)
            $display("FAIL basic_run_timing got rise=%0d lastwe=%0d overlap=%0d want rise=lastwe+1 overlap=0",
                     rise1, we_last1, overlap1);
        else passed++;
    endtask

    task automatic test_reload_run();
        word_q w;
        ent_q exp;
        int acc, low;
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reload = 1'b0;
        total++;
        if ({cpu_run1, load_done1, word_count1, s_ready1} !== {1'b0, 1'b0, 4'd0, 1'b1})
            $display("FAIL reload_stop got run=%b done=%b wc=%0d rdy=%b want 0 0 0 1",
                     cpu_run1, load_done1, word_count1, s_ready1);
        else passed++;
        clear_logs();
        w = '{32'hDEADBEEF};
        exp = model(w, 1'b1, 1'b1);
        drive(w, 1'b1, 1'b0, 0, acc, low);
        settle(1'b0);
        total++;
        if (log1 !== exp)
            $display("FAIL reload_writes got %0d writes first=%h want %0d first=%h",
                     log1.size(), (log1.size() > 0) ? log1[0] : '0, exp.size(), exp[0]);
        else passed++;
        total++;
        if ({cpu_run1, load_done1, word_count1} !== {1'b1, 1'b1, 4'd1})
            $display("FAIL reload_flags got run=%b done=%b wc=%0d want 1 1 1",
                     cpu_run1, load_done1, word_count1);
        else passed++;
    endtask

    task automatic test_bubbles();
        word_q w;
        ent_q exp;
        int acc, low;
        apply_reset();
        w = '{32'h20100005, 32'h20110003, 32'h02119020};
        exp = model(w, 1'b1, 1'b1);
        drive(w, 1'b1, 1'b0, 1, acc, low);
        settle(1'b0);
        total++;
        if (low !== 0) $display("FAIL bubble_ready got %0d low cycles want 0", low);
        else passed++;
        total++;
        if (log1 !== exp)
            $display("FAIL bubble_writes got %0d writes want %0d", log1.size(), exp.size());
        else passed++;
        total++;
        if (word_count1 !== 4'd3 || cpu_run1 !== 1'b1)
            $display("FAIL bubble_flags got wc=%0d run=%b want 3 1", word_count1, cpu_run1);
        else passed++;
    endtask

    task automatic test_overflow();
        word_q w;
        ent_q exp;
        int acc, low;
        apply_reset();
        w = rand_words(9);
        exp = model(w, 1'b0, 1'b1);
        drive(w, 1'b0, 1'b0, 2, acc, low);
        settle(1'b0);
        total++;
        if (acc !== 8 || low == 0)
            $display("FAIL ovf_accepts got acc=%0d stalled=%0d want 8 and >0", acc, low);
        else passed++;
        total++;
        if (log1 !== exp)
            $display("FAIL ovf_writes got %0d writes want %0d", log1.size(), exp.size());
        else passed++;
        total++;
        if ({s_ready1, error1, cpu_run1, load_done1, word_count1} !== {1'b0, 1'b1, 1'b0, 1'b0, 4'd8})
            $display("FAIL ovf_flags got rdy=%b err=%b run=%b done=%b wc=%0d want 0 1 0 0 8",
                     s_ready1, error1, cpu_run1, load_done1, word_count1);
        else passed++;
    endtask

    task automatic test_reload_err();
        word_q w;
        ent_q exp;
        int acc, low, n;
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reload = 1'b0;
        total++;
        if ({error1, s_ready1, word_count1} !== {1'b0, 1'b1, 4'd0})
            $display("FAIL err_reload got err=%b rdy=%b wc=%0d want 0 1 0",
                     error1, s_ready1, word_count1);
        else passed++;
        clear_logs();
        n = $urandom_range(1, DEPTH);
        w = rand_words(n);
        exp = model(w, 1'b1, 1'b1);
        drive(w, 1'b1, 1'b0, 2, acc, low);
        settle(1'b0);
        total++;
        if (log1 !== exp || word_count1 !== 4'(n) || cpu_run1 !== 1'b1)
            $display("FAIL err_reload_load got writes=%0d wc=%0d run=%b want %0d %0d 1",
                     log1.size(), word_count1, cpu_run1, exp.size(), n);
        else passed++;
    endtask

    task automatic test_reset_midload();
        word_q w, part;
        ent_q exp;
        int acc, low;
        apply_reset();
        w = rand_words(5);
        part = '{w[0], w[1]};
        drive(part, 1'b0, 1'b0, 0, acc, low);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({s_ready1, imem_we1, imem_addr1, imem_wdata1, cpu_run1, error1, word_count1} !== '0)
            $display("FAIL midload_reset got rdy=%b we=%b addr=%0d wd=%h run=%b err=%b wc=%0d want 0",
                     s_ready1, imem_we1, imem_addr1, imem_wdata1, cpu_run1, error1, word_count1);
        else passed++;
        reset = 1'b0;
        clear_logs();
        exp = model(w, 1'b1, 1'b1);
        drive(w, 1'b1, 1'b0, 2, acc, low);
        settle(1'b0);
        total++;
        if (log1 !== exp)
            $display("FAIL midload_writes got %0d writes first=%h want %0d first=%h",
                     log1.size(), (log1.size() > 0) ? log1[0] : '0, exp.size(), exp[0]);
        else passed++;
        total++;
        if (word_count1 !== 4'd5 || cpu_run1 !== 1'b1)
            $display("FAIL midload_flags got wc=%0d run=%b want 5 1", word_count1, cpu_run1);
        else passed++;
    endtask

    task automatic test_nofill();
        word_q w;
        ent_q exp;
        int acc, low, n;
        apply_reset();
        w = rand_words(DEPTH);
        exp = model(w, 1'b1, 1'b0);
        drive(w, 1'b1, 1'b1, 0, acc, low);
        settle(1'b1);
        total++;
        if (log0 !== exp)
            $display("FAIL nofill_full_writes got %0d want %0d", log0.size(), exp.size());
        else passed++;
        total++;
        if ({cpu_run0, load_done0, error0, word_count0} !== {1'b1, 1'b1, 1'b0, 4'd8})
            $display("FAIL nofill_flags got run=%b done=%b err=%b wc=%0d want 1 1 0 8",
                     cpu_run0, load_done0, error0, word_count0);
        else passed++;
        total++;
        if (rise0 !== we_last0 + 1 || overlap0 !== 0)
            $display("FAIL nofill_timing got rise=%0d lastwe=%0d overlap=%0d want rise=lastwe+1",
                     rise0, we_last0, overlap0);
        else passed++;
        apply_reset();
        n = $urandom_range(1, DEPTH - 2);
        w = rand_words(n);
        exp = model(w, 1'b1, 1'b0);
        drive(w, 1'b1, 1'b1, 2, acc, low);
        settle(1'b1);
        total++;
        if (log0 !== exp || word_count0 !== 4'(n) || cpu_run0 !== 1'b1)
            $display("FAIL nofill_short got writes=%0d wc=%0d run=%b want %0d %0d 1",
                     log0.size(), word_count0, cpu_run0, exp.size(), n);
        else passed++;
    endtask

    task automatic test_random();
        word_q w;
        ent_q exp;
        int acc, low, n;
        for (int t = 0; t < 4; t++) begin
            apply_reset();
            n = $urandom_range(1, DEPTH);
            w = rand_words(n);
            exp = model(w, 1'b1, 1'b1);
            drive(w, 1'b1, 1'b0, 2, acc, low);
            settle(1'b0);
            total++;
            if (log1 !== exp || word_count1 !== 4'(n))
                $display("FAIL random_load[%0d] got writes=%0d wc=%0d want %0d %0d",
                         t, log1.size(), word_count1, exp.size(), n);
            else passed++;
            total++;
            if (cpu_run1 !== 1'b1 || rise1 !== we_last1 + 1 || overlap1 !== 0)
                $display("FAIL random_run[%0d] got run=%b rise=%0d lastwe=%0d overlap=%0d",
                         t, cpu_run1, rise1, we_last1, overlap1);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reload_run();
        test_bubbles();
        test_overflow();
        test_reload_err();
        test_reset_midload();
        test_nofill();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
